// File: rtl/mouse_pos_uart_tx.sv
// mouse_pos_uart_tx
// Serialises the local player's mouse state (x, y, left click) into a fixed
// UART frame (8N1, LSB first) so the peer board can mirror this player.
// Frame bytes: A5, x[11:4], {x[3:0],y[11:8]}, y[7:0], {7'b0,click}
// [, XOR checksum of bytes 1..4 when MOUSE_TX_CHECKSUM_EN is defined].
// Each frame is followed by GAP_BITS idle bit-times.
//
// Optional feature macro: MOUSE_TX_CHECKSUM_EN (6-byte frames with checksum;
// undefined gives 5-byte frames and no checksum logic).
//
// Ports:
//   clk        in   system clock (pixel domain)
//   rst        in   asynchronous active-low reset
//   en         in   frame generation enable; sampled only in IDLE
//   xpos       in   12-bit limited x position
//   ypos       in   12-bit limited y position
//   click      in   limited left-button state
//   tx         out  registered UART line, idle high
//   busy       out  high from snapshot until the end of the gap
//   frame_done out  one-cycle pulse on the last cycle of the last stop bit
module mouse_pos_uart_tx #(
  parameter int CLK_HZ   = 65_000_000,
  parameter int BAUD     = 115_200,
  parameter int GAP_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        click,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
`ifdef MOUSE_TX_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_BITS - 1);
  localparam logic [2:0]       BYTE_LAST = 3'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt;
  logic [2:0]        r_byte_idx, w_byte_idx_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [24:0]       r_snap;   // {x[11:0], y[11:0], click}
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_bit_end;
  logic [7:0]        w_cur_byte;

  // Byte idx of the frame built from the snapshot register.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [24:0] snap);
    logic [7:0] b1, b2, b3, b4;
    b1 = snap[24:17];
    b2 = snap[16:9];
    b3 = snap[8:1];
    b4 = {7'b0, snap[0]};
    case (idx)
      3'd1:    return b1;
      3'd2:    return b2;
      3'd3:    return b3;
      3'd4:    return b4;
`ifdef MOUSE_TX_CHECKSUM_EN
      3'd5:    return b1 ^ b2 ^ b3 ^ b4;
`endif
      default: return 8'hA5;
    endcase
  endfunction

  assign w_bit_end = (r_bit_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and counter-next logic
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_bit_cnt_nxt  = w_bit_end ? '0 : r_bit_cnt + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_bit_cnt_nxt = '0;
        w_gap_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
        if (en) begin
          w_state_nxt    = S_START;
          w_byte_idx_nxt = '0;
        end
      end
      S_START: if (w_bit_end) begin
        w_state_nxt   = S_DATA;
        w_bit_idx_nxt = '0;
      end
      S_DATA: if (w_bit_end) begin
        if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
      end
      S_STOP: if (w_bit_end) begin
        if (r_byte_idx == BYTE_LAST) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = '0;
        end else begin
          w_state_nxt    = S_START;
          w_byte_idx_nxt = r_byte_idx + 3'd1;
        end
      end
      S_GAP: if (w_bit_end) begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
        else                       w_gap_cnt_nxt = r_gap_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. tx is computed from the next state so the line register
  // changes on the same edge as the state (tx falls on the snapshot edge).
  // DATA is never entered on the snapshot edge, so r_snap is already valid.
  always_comb begin
    w_cur_byte = frame_byte(w_byte_idx_nxt, r_snap);
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_cur_byte[w_bit_idx_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
    busy       = (r_state != S_IDLE);
    frame_done = (r_state == S_STOP) && w_bit_end && (r_byte_idx == BYTE_LAST);
  end

  // Counters, snapshot and line register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_gap_cnt  <= '0;
      r_snap     <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_tx       <= w_tx_nxt;
      if (r_state == S_IDLE && en) r_snap <= {xpos, ypos, click};
    end
  end

  assign tx = r_tx;

endmodule

// File: tb/tb_mouse_pos_uart_tx.sv
// Testbench for mouse_pos_uart_tx at 10 clocks per bit, 16 gap bits.
module tb_mouse_pos_uart_tx;
  localparam int CPB  = 10;
  localparam int GAPB = 16;
`ifdef MOUSE_TX_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int FRAME = NB * 10 * CPB;
  localparam int GAPC  = GAPB * CPB;
  localparam int CAP   = FRAME + GAPC + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        click = 1'b0;
  logic        tx, busy, frame_done;

  int total = 0;
  int bad = 0;
  logic cap_tx [CAP];
  logic cap_busy [CAP];
  logic cap_fd [CAP];

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        c;
    logic [47:0] exp;   // B0 in [47:40] ... B5 in [7:0]
  } vec_t;
  vec_t tbl [5];

  mouse_pos_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .GAP_BITS(GAPB)) dut (
    .clk(clk), .rst(rst), .en(en), .xpos(xpos), .ypos(ypos), .click(click),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference frame from plain arithmetic on the field values.
  function automatic logic [47:0] model_frame(input logic [11:0] x, input logic [11:0] y,
                                              input logic c);
    int v [6];
    v[0] = 'hA5;
    v[1] = int'(x) / 16;
    v[2] = (int'(x) % 16) * 16 + int'(y) / 256;
    v[3] = int'(y) % 256;
    v[4] = c ? 1 : 0;
    v[5] = v[1] ^ v[2] ^ v[3] ^ v[4];
    return {v[0][7:0], v[1][7:0], v[2][7:0], v[3][7:0], v[4][7:0], v[5][7:0]};
  endfunction

  // Returns number of negedges until tx is seen low; limit+1 on timeout.
  task automatic wait_fall(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n <= limit);
  endtask

  // Index 0 is the first cycle with tx low.
  task automatic capture(input int chg_at, input logic [11:0] nx, input int drop_at);
    for (int i = 0; i < CAP; i++) begin
      if (i > 0) @(negedge clk);
      cap_tx[i]   = tx;
      cap_busy[i] = busy;
      cap_fd[i]   = frame_done;
      if (i == chg_at) xpos = nx;
      if (i == drop_at) en = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp);
    logic [7:0] got;
    int fd_cnt, fd_idx, berr, terr;
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("%s_start%0d", tag, b), cap_tx[b*10*CPB + CPB/2], 1'b0);
      for (int i = 0; i < 8; i++) got[i] = cap_tx[b*10*CPB + (i+1)*CPB + CPB/2];
      chk($sformatf("%s_byte%0d", tag, b), got, exp[47-8*b -: 8]);
      chk($sformatf("%s_stop%0d", tag, b), cap_tx[b*10*CPB + 9*CPB + CPB/2], 1'b1);
    end
    fd_cnt = 0; fd_idx = -1; berr = 0; terr = 0;
    for (int i = 0; i < CAP; i++) begin
      if (cap_fd[i] !== 1'b0) begin fd_cnt++; fd_idx = i; end
      if (i < FRAME + GAPC) begin if (cap_busy[i] !== 1'b1) berr++; end
      else if (cap_busy[i] !== 1'b0) berr++;
      if (i >= FRAME && cap_tx[i] !== 1'b1) terr++;
    end
    chk({tag, "_fd_count"}, fd_cnt, 1);
    chk({tag, "_fd_cycle"}, fd_idx, FRAME - 1);
    chk({tag, "_busy_errs"}, berr, 0);
    chk({tag, "_gap_tx_errs"}, terr, 0);
  endtask

  initial begin
    int n, errs;
    logic [11:0] rx, ry;
    logic rc;

    tbl[0] = '{12'h3A7, 12'h2B4, 1'b1, 48'hA5_3A_72_B4_01_FD};
    tbl[1] = '{12'h000, 12'h2B4, 1'b1, 48'hA5_00_02_B4_01_B7};
    tbl[2] = '{12'hFFF, 12'hFFF, 1'b0, 48'hA5_FF_FF_FF_00_FF};
    tbl[3] = '{12'h000, 12'h000, 1'b0, 48'hA5_00_00_00_00_00};
    tbl[4] = '{12'h5A5, 12'h0C3, 1'b1, 48'hA5_5A_50_C3_01_C8};

    // Reset state, with en high while in reset
    #2 rst = 1'b0;
    en = 1'b1;
    #2;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fd", frame_done, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_hold_tx", tx, 1'b1);
    en = 1'b0;
    rst = 1'b1;

    // en low from reset: line stays idle
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
    end
    chk("idle_10000", errs, 0);

    // Table vectors
    for (int k = 0; k < 5; k++) begin
      xpos = tbl[k].x; ypos = tbl[k].y; click = tbl[k].c; en = 1'b1;
      wait_fall(20, n);
      chk($sformatf("tbl%0d_latency", k), n, 1);
      capture(-1, 12'h000, -1);
      check_frame($sformatf("tbl%0d", k), tbl[k].exp);
      en = 1'b0;
      wait_fall(50, n);
      chk($sformatf("tbl%0d_no_refire", k), n, 51);
    end

    // Input change mid-frame, then back-to-back frame with en held
    xpos = 12'h3A7; ypos = 12'h2B4; click = 1'b1; en = 1'b1;
    wait_fall(20, n);
    chk("chg_latency", n, 1);
    capture(20, 12'h000, -1);
    check_frame("chg_f1", tbl[0].exp);
    wait_fall(20, n);
    chk("chg_period", n, 1);
    capture(-1, 12'h000, -1);
    check_frame("chg_f2", tbl[1].exp);
    en = 1'b0;
    wait_fall(50, n);
    chk("chg_no_refire", n, 51);

    // Randomized frames against the reference model
    for (int k = 0; k < 6; k++) begin
      rx = 12'($urandom_range(0, 4095));
      ry = 12'($urandom_range(0, 4095));
      rc = 1'($urandom_range(0, 1));
      xpos = rx; ypos = ry; click = rc; en = 1'b1;
      wait_fall(20, n);
      chk($sformatf("rnd%0d_latency", k), n, 1);
      xpos = ~rx; ypos = ~ry; click = ~rc;
      capture(-1, 12'h000, -1);
      check_frame($sformatf("rnd%0d", k), model_frame(rx, ry, rc));
      en = 1'b0;
      wait_fall(50, n);
      chk($sformatf("rnd%0d_no_refire", k), n, 51);
    end

    // en dropped during B2: frame and gap complete, then nothing more
    xpos = 12'h1C9; ypos = 12'hE35; click = 1'b0; en = 1'b1;
    wait_fall(20, n);
    chk("drop_latency", n, 1);
    capture(-1, 12'h000, 2 * 10 * CPB + 50);
    check_frame("drop", model_frame(12'h1C9, 12'hE35, 1'b0));
    wait_fall(200, n);
    chk("drop_no_frame", n, 201);
    chk("drop_busy", busy, 1'b0);

    // Reset asserted during B0 data bit 1 (a low bit)
    xpos = 12'h3A7; ypos = 12'h2B4; click = 1'b1; en = 1'b1;
    wait_fall(20, n);
    repeat (25) @(negedge clk);
    chk("rstmid_pre_tx", tx, 1'b0);
    chk("rstmid_pre_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_tx", tx, 1'b1);
    chk("rstmid_busy", busy, 1'b0);
    @(negedge clk);
    xpos = 12'h842; ypos = 12'h17F; click = 1'b0;
    rst = 1'b1;
    wait_fall(20, n);
    chk("rstmid_restart", n, 1);
    capture(-1, 12'h000, -1);
    check_frame("rstmid", model_frame(12'h842, 12'h17F, 1'b0));
    en = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mouse_pos_uart_tx.md
# mouse_pos_uart_tx

Serialises the local player's limited mouse state (x, y, left click) into a fixed-format UART frame so the peer board can mirror this player. It sits directly downstream of the mouse front end and consumes its muxed outputs: 12-bit x, 12-bit y and the limited click. It runs in the 65 MHz pixel domain and drives one board pin toward the opponent's receiver.

## Interface
- CLK_HZ, 65_000_000, input clock frequency in Hz
- BAUD, 115_200, line rate; CLKS_PER_BIT = CLK_HZ / BAUD (integer division, truncating; 564 at defaults)
- GAP_BITS, 16, idle bit-times inserted after every frame
- clk  input  1  system clock (65 MHz)
- rst  input  1  asynchronous, active-low reset
- en  input  1  frame generation enable (mouse control active)
- xpos  input  12  limited x position
- ypos  input  12  limited y position
- click  input  1  limited left-button state
- tx  output  1  UART line, idle high
- busy  output  1  high from snapshot until the end of the GAP state
- frame_done  output  1  one-cycle pulse on the last cycle of the last stop bit

## Operation
- States: IDLE, START, DATA, STOP, GAP.
- IDLE: tx=1, busy=0. When en=1, capture {xpos, ypos, click} into a snapshot register on that same edge, load byte index 0, go to START.
- Frame bytes, sent in order: B0=0xA5, B1=x[11:4], B2={x[3:0], y[11:8]}, B3=y[7:0], B4={7'b0, click}, B5=B1^B2^B3^B4 (checksum; see Configuration).
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits LSB first, each held for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. If more bytes remain, increment the index and go to START with no inter-byte gap. Otherwise pulse frame_done and go to GAP.
- GAP: tx=1 for GAP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Inputs are sampled only at snapshot. Changes mid-frame do not affect the frame in flight.
- en deasserted mid-frame: the current frame, including GAP, completes. Re-entry to START is blocked in IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1, sized by $clog2. The gap counter is a separate bit counter. No wrap beyond terminal counts.

## Timing
- Reset values: tx=1, busy=0, frame_done=0, state=IDLE, snapshot=0, all counters 0.
- Reset asserted mid-frame: tx goes to 1 asynchronously and the frame is abandoned. After release, a new frame starts with a new snapshot.
- The snapshot edge is the first START cycle, so tx falls one clk after the IDLE cycle with en=1. busy rises on the same edge.
- Frame length: NBYTES*10*CLKS_PER_BIT cycles from the first START cycle to the end of the last STOP cycle. NBYTES is 6, or 5 without checksum.
- Frame period with en held high: (NBYTES*10 + GAP_BITS)*CLKS_PER_BIT + 1 cycles, where the +1 is the IDLE cycle.
- tx is registered, with no combinational path from inputs to tx.

## Configuration
- MOUSE_TX_CHECKSUM_EN defined: 6-byte frames, with B5 the XOR checksum.
- Not defined: 5-byte frames. The frame ends after B4 and frame_done pulses at the end of B4's stop bit. No checksum logic is synthesised.

## Test plan
- CLK_HZ=1_000_000, BAUD=100_000 (10 clks/bit), checksum on. Hold en=1, x=0x3A7, y=0x2B4, click=1 → decoded bytes A5 3A 72 B4 01 FD; frame_done at cycle 600 after the first tx fall.
- Same stimulus, macro undefined → bytes A5 3A 72 B4 01; frame_done at cycle 500; next tx fall 661 cycles after the previous one (GAP_BITS=16).
- Change x to 0x000 20 cycles into the frame → the frame still carries 3A 72. The next frame carries 00 02 B4 01 and checksum B7.
- Drop en during byte B2 → the frame completes. tx then stays high, busy falls after GAP, and there is no further frame.
- Assert rst mid-DATA → tx=1 and busy=0 immediately. After release with en=1, a fresh frame begins with an A5 header.
- en=0 from reset → tx stays 1 and busy stays 0 for 10000 cycles.
